// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state and trigger-mode encodings for the trace capture block
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_IMM           = 2'd0;
  localparam logic [1:0] TRIG_PC            = 2'd1;
  localparam logic [1:0] TRIG_STATUS        = 2'd2;
  localparam logic [1:0] TRIG_PC_AND_STATUS = 2'd3;

  // Trigger decision from the registered mode and the two per-sample match terms
  function automatic logic trig_hit(input logic [1:0] mode, input logic pc_eq, input logic st_hit);
    case (mode)
      TRIG_IMM:           trig_hit = 1'b1;
      TRIG_PC:            trig_hit = pc_eq;
      TRIG_STATUS:        trig_hit = st_hit;
      TRIG_PC_AND_STATUS: trig_hit = pc_eq & st_hit;
      default:            trig_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace storage, synchronous write, combinational read
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 100
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; validity is tracked by the capture pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - triggered instruction trace capture with oldest-first readout
module trace_capture
  import trace_pkg::*;
#(
  parameter int PC_WIDTH     = 64,
  parameter int INSTR_WIDTH  = 32,
  parameter int STATUS_WIDTH = 4,
  parameter int DEPTH        = 16,
  parameter int POST_COUNT   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [PC_WIDTH-1:0]     pc_in,
  input  logic [INSTR_WIDTH-1:0]  instr_in,
  input  logic [STATUS_WIDTH-1:0] status_in,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [1:0]              trig_mode,
  input  logic [PC_WIDTH-1:0]     trig_pc,
  input  logic [STATUS_WIDTH-1:0] trig_mask,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PC_WIDTH-1:0]     rd_pc,
  output logic [INSTR_WIDTH-1:0]  rd_instr,
  output logic [STATUS_WIDTH-1:0] rd_status,
  output logic                    rd_last,
  output logic [1:0]              state,
  output logic                    wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_WIDTH + INSTR_WIDTH + STATUS_WIDTH;
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_COUNT > 0) ? POST_COUNT - 1 : 0);

  state_t                  st;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           post_cnt;
  logic [AW:0]             fill;
  logic [1:0]              cfg_mode;
  logic [PC_WIDTH-1:0]     cfg_pc;
  logic [STATUS_WIDTH-1:0] cfg_mask;

  logic          we;
  logic          hit;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] rdata;

  assign we  = (st == ST_ARMED || st == ST_POST) && sample_valid && !abort;
  assign hit = trig_hit(cfg_mode, pc_in == cfg_pc, |(status_in & cfg_mask));

  // During readout fill counts the entries still owed, so wr_ptr - fill is always the next-oldest
  assign rd_addr = wr_ptr - fill[AW-1:0];

  trace_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({pc_in, instr_in, status_in}),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  assign state    = st;
  assign rd_valid = (st == ST_READOUT);
  assign rd_last  = rd_valid && (fill == ONE);
  assign {rd_pc, rd_instr, rd_status} = rd_valid ? rdata : '0;

  // Capture/readout sequencer; abort outranks every other event in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      fill     <= '0;
      wrapped  <= 1'b0;
      cfg_mode <= TRIG_IMM;
      cfg_pc   <= '0;
      cfg_mask <= '0;
    end else if (abort) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      fill     <= '0;
      wrapped  <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill == FULL) wrapped <= 1'b1;
        else              fill    <= fill + 1'b1;
      end
      case (st)
        ST_IDLE: begin
          if (arm) begin
            st       <= ST_ARMED;
            wr_ptr   <= '0;
            post_cnt <= '0;
            fill     <= '0;
            wrapped  <= 1'b0;
            cfg_mode <= trig_mode;
            cfg_pc   <= trig_pc;
            cfg_mask <= trig_mask;
          end
        end
        ST_ARMED: begin
          if (sample_valid && hit) begin
            post_cnt <= '0;
            st       <= (POST_COUNT == 0) ? ST_READOUT : ST_POST;
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            if (post_cnt == POST_LAST) st       <= ST_READOUT;
            else                       post_cnt <= post_cnt + 1'b1;
          end
        end
        ST_READOUT: begin
          if (rd_ready) begin
            fill <= fill - 1'b1;
            if (fill == ONE) st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - table-driven and directed checks of trace_capture
module tb_trace_capture;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [63:0] pc_in;
  logic [31:0] instr_in;
  logic [3:0]  status_in;
  logic        arm;
  logic        abort;
  logic [1:0]  trig_mode;
  logic [63:0] trig_pc;
  logic [3:0]  trig_mask;
  logic        rd_ready;

  logic        rd_valid_a, rd_last_a, wrapped_a;
  logic [63:0] rd_pc_a;
  logic [31:0] rd_instr_a;
  logic [3:0]  rd_status_a;
  logic [1:0]  state_a;

  logic        rd_valid_b, rd_last_b, wrapped_b;
  logic [63:0] rd_pc_b;
  logic [31:0] rd_instr_b;
  logic [3:0]  rd_status_b;
  logic [1:0]  state_b;

  trace_capture u_dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .pc_in(pc_in), .instr_in(instr_in), .status_in(status_in),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_mask(trig_mask),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_pc(rd_pc_a), .rd_instr(rd_instr_a),
    .rd_status(rd_status_a), .rd_last(rd_last_a), .state(state_a), .wrapped(wrapped_a)
  );

  trace_capture #(.POST_COUNT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .pc_in(pc_in), .instr_in(instr_in), .status_in(status_in),
    .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_mask(trig_mask),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_pc(rd_pc_b), .rd_instr(rd_instr_b),
    .rd_status(rd_status_b), .rd_last(rd_last_b), .state(state_b), .wrapped(wrapped_b)
  );

  bit          sel;
  logic        m_valid, m_last, m_wrapped;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [3:0]  m_status;
  logic [1:0]  m_state;

  assign m_valid   = sel ? rd_valid_b  : rd_valid_a;
  assign m_last    = sel ? rd_last_b   : rd_last_a;
  assign m_wrapped = sel ? wrapped_b   : wrapped_a;
  assign m_pc      = sel ? rd_pc_b     : rd_pc_a;
  assign m_instr   = sel ? rd_instr_b  : rd_instr_a;
  assign m_status  = sel ? rd_status_b : rd_status_a;
  assign m_state   = sel ? state_b     : state_a;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [63:0] tpc, input logic [3:0] tmask);
    trig_mode = mode;
    trig_pc   = tpc;
    trig_mask = tmask;
    arm       = 1'b1;
    step();
    arm       = 1'b0;
  endtask

  function automatic logic [3:0] exp_status(input logic [31:0] bits, input int idx);
    return bits[idx] ? 4'b0100 : 4'b0011;
  endfunction

  task automatic feed(input logic [63:0] base, input int n, input logic [31:0] bits);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      pc_in        = base + 64'(4 * i);
      instr_in     = 32'hA000_0000 + 32'(i);
      status_in    = exp_status(bits, i);
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_readout(input string tag);
    int n = 0;
    while (m_state != 2'd3 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".reach_readout"}, 64'(m_state), 64'd3);
  endtask

  task automatic drain(input string tag, input logic [63:0] base, input int first, input int n,
                       input logic [31:0] bits, input bit exp_wrap);
    chk({tag, ".wrapped"}, 64'(m_wrapped), 64'(exp_wrap));
    rd_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk({tag, ".valid"},  64'(m_valid),  64'd1);
      chk({tag, ".pc"},     m_pc,          base + 64'(4 * (first + k)));
      chk({tag, ".instr"},  64'(m_instr),  64'(32'hA000_0000 + 32'(first + k)));
      chk({tag, ".status"}, 64'(m_status), 64'(exp_status(bits, first + k)));
      chk({tag, ".last"},   64'(m_last),   64'(k == n - 1));
      step();
    end
    rd_ready = 1'b0;
    chk({tag, ".idle_after"},  64'(m_state), 64'd0);
    chk({tag, ".valid_after"}, 64'(m_valid), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] tpc;
    logic [3:0]  tmask;
    int          nsamp;
    logic [31:0] bits;
    bit          use0;
    int          exp_n;
    int          exp_first;
    bit          exp_wrap;
  } vec_t;

  vec_t vecs[4];

  initial begin
    // Mode 0: trigger on first sample, 8 post samples -> idx 0..8
    vecs[0] = '{2'd0, 64'h0,    4'h0,    12, 32'h0,  1'b0, 9,  0, 1'b0};
    // Mode 1 at PC 0x40 (idx 16), post idx 17..24, 16 kept -> idx 9..24 (PC 0x24..0x60)
    vecs[1] = '{2'd1, 64'h40,   4'h0,    30, 32'h0,  1'b0, 16, 9, 1'b1};
    // Mode 2 with POST_COUNT=0 instance: status bit2 on idx 2 -> idx 0..2
    vecs[2] = '{2'd2, 64'hFFFF, 4'b0100, 6,  32'h4,  1'b1, 3,  0, 1'b0};
    // Mode 3: status hit on idx 3 and 6, PC match on idx 6 -> trigger 6, idx 0..14
    vecs[3] = '{2'd3, 64'h18,   4'b0100, 20, 32'h48, 1'b0, 15, 0, 1'b0};

    sel = 1'b0;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    pc_in = '0;
    instr_in = '0;
    status_in = '0;
    arm = 1'b0;
    abort = 1'b0;
    trig_mode = '0;
    trig_pc = '0;
    trig_mask = '0;
    rd_ready = 1'b0;

    #1;
    chk("reset.state",   64'(state_a),    64'd0);
    chk("reset.valid",   64'(rd_valid_a), 64'd0);
    chk("reset.last",    64'(rd_last_a),  64'd0);
    chk("reset.pc",      rd_pc_a,         64'd0);
    chk("reset.wrapped", 64'(wrapped_a),  64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      sel = vecs[v].use0;
      do_abort();
      do_arm(vecs[v].mode, vecs[v].tpc, vecs[v].tmask);
      chk($sformatf("vec%0d.armed", v), 64'(m_state), 64'd1);
      feed(64'h0, vecs[v].nsamp, vecs[v].bits);
      wait_readout($sformatf("vec%0d", v));
      drain($sformatf("vec%0d", v), 64'h0, vecs[v].exp_first, vecs[v].exp_n,
            vecs[v].bits, vecs[v].exp_wrap);
    end

    // Stalled readout: rd_ready cycles 1,0,0,1 and every entry must appear once, held while stalled
    sel = 1'b0;
    do_abort();
    do_arm(2'd0, 64'h0, 4'h0);
    feed(64'h300, 12, 32'h0);
    wait_readout("stall");
    begin
      logic [3:0] pat;
      int k;
      int c;
      pat = 4'b1001;
      k = 0;
      c = 0;
      while (k < 9 && c < 60) begin
        rd_ready = pat[c % 4];
        chk("stall.valid", 64'(rd_valid_a), 64'd1);
        chk("stall.pc",    rd_pc_a,         64'h300 + 64'(4 * k));
        chk("stall.last",  64'(rd_last_a),  64'(k == 8));
        if (rd_ready) k++;
        step();
        c++;
      end
      rd_ready = 1'b0;
      chk("stall.count", 64'(k), 64'd9);
      chk("stall.idle",  64'(state_a), 64'd0);
    end

    // abort and arm together while ARMED: abort wins, next capture starts clean
    do_abort();
    do_arm(2'd1, 64'hFFFF_FFFF, 4'h0);
    feed(64'h400, 3, 32'h0);
    chk("abort_arm.armed", 64'(state_a), 64'd1);
    abort = 1'b1;
    arm   = 1'b1;
    trig_mode = 2'd0;
    step();
    abort = 1'b0;
    arm   = 1'b0;
    chk("abort_arm.state",   64'(state_a),    64'd0);
    chk("abort_arm.valid",   64'(rd_valid_a), 64'd0);
    chk("abort_arm.wrapped", 64'(wrapped_a),  64'd0);
    do_arm(2'd0, 64'h0, 4'h0);
    feed(64'h500, 12, 32'h0);
    wait_readout("after_abort");
    drain("after_abort", 64'h500, 0, 9, 32'h0, 1'b0);

    // Asynchronous reset in the middle of POST
    do_arm(2'd0, 64'h0, 4'h0);
    feed(64'h600, 3, 32'h0);
    chk("rst_mid.post", 64'(state_a), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.state", 64'(state_a),    64'd0);
    chk("rst_mid.valid", 64'(rd_valid_a), 64'd0);
    chk("rst_mid.last",  64'(rd_last_a),  64'd0);
    chk("rst_mid.pc",    rd_pc_a,         64'd0);
    step();
    rst_n = 1'b1;
    step();
    do_arm(2'd0, 64'h0, 4'h0);
    feed(64'h700, 12, 32'h0);
    wait_readout("after_rst");
    drain("after_rst", 64'h700, 0, 9, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
